// File: rtl/axil_to_wb.sv
// axil_to_wb: AXI4-Lite slave to Wishbone classic master bridge, one transaction in flight.
// Ports:
//   clk, rst                       : sole clock, synchronous active-high reset
//   s_axi_aw*, s_axi_w*, s_axi_b*  : AXI4-Lite write address, write data, write response
//   s_axi_ar*, s_axi_r*            : AXI4-Lite read address, read data
//   wb_adr/dat_w/sel/we/cyc/stb    : Wishbone classic master request
//   wb_dat_r/ack/err               : Wishbone response
module axil_to_wb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_w,
    output logic [3:0]  wb_sel,
    output logic        wb_we,
    output logic        wb_cyc,
    output logic        wb_stb,
    input  logic [31:0] wb_dat_r,
    input  logic        wb_ack,
    input  logic        wb_err
);
    typedef enum logic [2:0] {IDLE, WB_WR, WB_RD, B_RESP, R_RESP} state_t;
    state_t      state, state_next;
    logic        aw_held, w_held, ar_held, last_wr;
    logic [31:0] aw_addr, w_data, ar_addr;
    logic [3:0]  w_strb;
    logic [15:0] cnt;
    logic        in_wb, contend, go_wr, go_rd, done;
    logic [1:0]  resp;

    assign s_axi_awready = !rst && state == IDLE && !aw_held;
    assign s_axi_wready  = !rst && state == IDLE && !w_held;
    assign s_axi_arready = !rst && state == IDLE && !ar_held;
    assign wb_stb        = wb_cyc;

    // Grant history only moves on contested grants, so a lone request never
    // costs the other type its turn the next time both are pending.
    always_comb begin
        in_wb      = state == WB_WR || state == WB_RD;
        contend    = state == IDLE && aw_held && w_held && ar_held;
        go_wr      = state == IDLE && aw_held && w_held && !(ar_held && last_wr);
        go_rd      = state == IDLE && ar_held && !go_wr;
        done       = in_wb && (wb_ack || wb_err || cnt == 16'(TIMEOUT - 1));
        resp       = (wb_ack && !wb_err) ? 2'b00 : 2'b10;
        state_next = state;
        case (state)
            IDLE:    state_next = go_wr ? WB_WR : go_rd ? WB_RD : IDLE;
            WB_WR:   state_next = done ? B_RESP : WB_WR;
            WB_RD:   state_next = done ? R_RESP : WB_RD;
            B_RESP:  state_next = s_axi_bready ? IDLE : B_RESP;
            R_RESP:  state_next = s_axi_rready ? IDLE : R_RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            ar_held      <= 1'b0;
            last_wr      <= 1'b0;
            aw_addr      <= '0;
            w_data       <= '0;
            w_strb       <= '0;
            ar_addr      <= '0;
            cnt          <= '0;
            wb_cyc       <= 1'b0;
            wb_we        <= 1'b0;
            wb_adr       <= '0;
            wb_dat_w     <= '0;
            wb_sel       <= '0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= 2'b00;
            s_axi_rvalid <= 1'b0;
            s_axi_rresp  <= 2'b00;
            s_axi_rdata  <= '0;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held <= 1'b1;
                aw_addr <= s_axi_awaddr;
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (s_axi_arvalid && s_axi_arready) begin
                ar_held <= 1'b1;
                ar_addr <= s_axi_araddr;
            end
            if (contend) last_wr <= go_wr;
            if (go_wr || go_rd) begin
                wb_cyc   <= 1'b1;
                wb_we    <= go_wr;
                wb_adr   <= go_wr ? aw_addr : ar_addr;
                wb_dat_w <= go_wr ? w_data : '0;
                wb_sel   <= go_wr ? w_strb : 4'hF;
                cnt      <= '0;
            end else if (in_wb) begin
                cnt <= cnt + 16'd1;
            end
            if (done) begin
                wb_cyc   <= 1'b0;
                wb_we    <= 1'b0;
                wb_adr   <= '0;
                wb_dat_w <= '0;
                wb_sel   <= '0;
                if (state == WB_WR) begin
                    s_axi_bvalid <= 1'b1;
                    s_axi_bresp  <= resp;
                end else begin
                    s_axi_rvalid <= 1'b1;
                    s_axi_rresp  <= resp;
                    s_axi_rdata  <= resp == 2'b00 ? wb_dat_r : '0;
                end
            end
            if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
            end
            if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
                ar_held      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axil_to_wb.sv
// tb_axil_to_wb: scoreboard bench for the AXI4-Lite to Wishbone bridge.
module tb_axil_to_wb;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
    logic        s_axi_bready = 1'b0, s_axi_rready = 1'b0;
    logic        s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata, wb_adr, wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_cyc, wb_stb;
    logic [31:0] wb_dat_r = '0;
    logic        wb_ack = 1'b0, wb_err = 1'b0;

    typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; } wb_t;
    typedef struct { logic wr; logic [1:0] resp; logic [31:0] data; } rsp_t;
    wb_t  wb_exp[$];
    rsp_t sb[$];
    wb_t  cur;

    int checks = 0, errors = 0;
    int cyc = 0, ar_hs_cyc = 0, rv_cyc = 0, stb_len = 0, last_stb_len = 0;
    int slv_mode = 0;
    logic [31:0] slv_data = '0;
    logic req_seen = 1'b0;

    axil_to_wb #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_we(wb_we),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb),
        .wb_dat_r(wb_dat_r), .wb_ack(wb_ack), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave: registered one-cycle ack (mode 0), err (mode 1) or silence (mode 2).
    always @(posedge clk) begin
        wb_ack   <= !rst && wb_stb && !wb_ack && !wb_err && slv_mode == 0;
        wb_err   <= !rst && wb_stb && !wb_ack && !wb_err && slv_mode == 1;
        wb_dat_r <= slv_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wb_stb && !req_seen) begin
            req_seen = 1'b1;
            stb_len  = 0;
            check("wb_start_expected", 32'(wb_exp.size() != 0), 32'(1));
            if (wb_exp.size() != 0) begin
                cur = wb_exp.pop_front();
                check("wb_we", 32'(wb_we), 32'(cur.we));
                check("wb_adr", wb_adr, cur.adr);
                check("wb_dat_w", wb_dat_w, cur.dat);
                check("wb_sel", 32'(wb_sel), 32'(cur.sel));
                check("wb_cyc", 32'(wb_cyc), 32'(1));
            end
        end
        if (wb_stb) begin
            stb_len++;
            check("wb_adr_hold", wb_adr, cur.adr);
            check("wb_dat_hold", wb_dat_w, cur.dat);
        end else if (req_seen) begin
            req_seen     = 1'b0;
            last_stb_len = stb_len;
        end
    end

    task automatic push_wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
        wb_t e;
        e.we = we; e.adr = adr; e.dat = dat; e.sel = sel;
        wb_exp.push_back(e);
    endtask

    task automatic push_rsp(input logic wr, input logic [1:0] resp, input logic [31:0] data);
        rsp_t e;
        e.wr = wr; e.resp = resp; e.data = data;
        sb.push_back(e);
    endtask

    task automatic issue(input logic a, input logic w, input logic r);
        int   n = 0;
        logic ha, hw, hr;
        s_axi_awvalid = a; s_axi_wvalid = w; s_axi_arvalid = r;
        while ((s_axi_awvalid || s_axi_wvalid || s_axi_arvalid) && n < 50) begin
            ha = s_axi_awvalid && s_axi_awready;
            hw = s_axi_wvalid && s_axi_wready;
            hr = s_axi_arvalid && s_axi_arready;
            @(negedge clk);
            n++;
            if (ha) s_axi_awvalid = 1'b0;
            if (hw) s_axi_wvalid = 1'b0;
            if (hr) begin
                s_axi_arvalid = 1'b0;
                ar_hs_cyc     = cyc;
            end
        end
        check("issue_accepted", 32'(s_axi_awvalid || s_axi_wvalid || s_axi_arvalid), 32'(0));
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    endtask

    task automatic collect(input int bp);
        rsp_t        e;
        int          n = 0;
        logic [31:0] d;
        while (!s_axi_bvalid && !s_axi_rvalid && n < 100) begin
            @(negedge clk);
            n++;
        end
        rv_cyc = cyc;
        check("resp_valid", 32'(s_axi_bvalid | s_axi_rvalid), 32'(1));
        if (!(s_axi_bvalid | s_axi_rvalid)) return;
        check("resp_expected", 32'(sb.size() != 0), 32'(1));
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check("resp_channel", 32'(s_axi_bvalid), 32'(e.wr));
        check("resp_one_valid", 32'(s_axi_bvalid & s_axi_rvalid), 32'(0));
        check("resp_code", 32'(e.wr ? s_axi_bresp : s_axi_rresp), 32'(e.resp));
        if (!e.wr) check("rdata", s_axi_rdata, e.data);
        d = s_axi_rdata;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(s_axi_bvalid | s_axi_rvalid), 32'(1));
            check("bp_rdata", s_axi_rdata, d);
            check("bp_resp", 32'(e.wr ? s_axi_bresp : s_axi_rresp), 32'(e.resp));
            check("bp_arready", 32'(s_axi_arready), 32'(0));
        end
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        check("resp_cleared", 32'(s_axi_bvalid | s_axi_rvalid), 32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(s_axi_awready), 32'(0));
        check("rst_wready", 32'(s_axi_wready), 32'(0));
        check("rst_arready", 32'(s_axi_arready), 32'(0));
        check("rst_bvalid", 32'(s_axi_bvalid), 32'(0));
        check("rst_rvalid", 32'(s_axi_rvalid), 32'(0));
        check("rst_resp", 32'({s_axi_bresp, s_axi_rresp}), 32'(0));
        check("rst_rdata", s_axi_rdata, 32'(0));
        check("rst_wb_ctl", 32'({wb_cyc, wb_stb, wb_we, wb_sel}), 32'(0));
        check("rst_wb_adr", wb_adr, 32'(0));
        check("rst_wb_dat", wb_dat_w, 32'(0));
        rst = 1'b0;
        @(negedge clk);
        check("idle_readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'(3'b111));

        // Basic read with latency measurement
        slv_data = 32'hDEADBEEF; s_axi_araddr = 32'h1000_0004;
        push_wb(1'b0, 32'h1000_0004, 32'h0, 4'hF);
        push_rsp(1'b0, 2'b00, 32'hDEADBEEF);
        issue(1'b0, 1'b0, 1'b1);
        collect(0);
        check("rd_latency", 32'(rv_cyc - ar_hs_cyc), 32'(3));

        // W before AW
        s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'b0011; s_axi_awaddr = 32'h2000_0000;
        push_wb(1'b1, 32'h2000_0000, 32'hCAFEF00D, 4'b0011);
        push_rsp(1'b1, 2'b00, 32'h0);
        issue(1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("w_only_no_cyc", 32'(wb_cyc), 32'(0));
        check("w_only_wready", 32'(s_axi_wready), 32'(0));
        check("w_only_awready", 32'(s_axi_awready), 32'(1));
        issue(1'b1, 1'b0, 1'b0);
        collect(0);

        // Simultaneous pairs: write first after reset, then read first
        do_reset();
        s_axi_awaddr = 32'h3000_0000; s_axi_wdata = 32'h1111_2222; s_axi_wstrb = 4'hF;
        s_axi_araddr = 32'h3000_0010; slv_data = 32'h3333_4444;
        push_wb(1'b1, 32'h3000_0000, 32'h1111_2222, 4'hF);
        push_wb(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        push_rsp(1'b1, 2'b00, 32'h0);
        push_rsp(1'b0, 2'b00, 32'h3333_4444);
        issue(1'b1, 1'b1, 1'b1);
        collect(0);
        collect(0);
        s_axi_awaddr = 32'h4000_0000; s_axi_wdata = 32'h5555_6666; s_axi_wstrb = 4'hC;
        s_axi_araddr = 32'h4000_0020; slv_data = 32'h7777_8888;
        push_wb(1'b0, 32'h4000_0020, 32'h0, 4'hF);
        push_wb(1'b1, 32'h4000_0000, 32'h5555_6666, 4'hC);
        push_rsp(1'b0, 2'b00, 32'h7777_8888);
        push_rsp(1'b1, 2'b00, 32'h0);
        issue(1'b1, 1'b1, 1'b1);
        collect(0);
        collect(0);

        // Wishbone error on write and read
        slv_mode = 1; slv_data = 32'h1234_5678;
        s_axi_awaddr = 32'h5000_0000; s_axi_wdata = 32'hA5A5_A5A5; s_axi_wstrb = 4'h1;
        push_wb(1'b1, 32'h5000_0000, 32'hA5A5_A5A5, 4'h1);
        push_rsp(1'b1, 2'b10, 32'h0);
        issue(1'b1, 1'b1, 1'b0);
        collect(0);
        s_axi_araddr = 32'h5000_0008;
        push_wb(1'b0, 32'h5000_0008, 32'h0, 4'hF);
        push_rsp(1'b0, 2'b10, 32'h0);
        issue(1'b0, 1'b0, 1'b1);
        collect(0);

        // Timeout with silent slave, then a normal write
        slv_mode = 2; s_axi_araddr = 32'h6000_0000;
        push_wb(1'b0, 32'h6000_0000, 32'h0, 4'hF);
        push_rsp(1'b0, 2'b10, 32'h0);
        issue(1'b0, 1'b0, 1'b1);
        collect(0);
        check("timeout_len", 32'(last_stb_len), 32'(8));
        slv_mode = 0;
        s_axi_awaddr = 32'h6000_0004; s_axi_wdata = 32'h0BAD_F00D; s_axi_wstrb = 4'h6;
        push_wb(1'b1, 32'h6000_0004, 32'h0BAD_F00D, 4'h6);
        push_rsp(1'b1, 2'b00, 32'h0);
        issue(1'b1, 1'b1, 1'b0);
        collect(0);

        // Read response back-pressure
        slv_data = 32'hFEED_FACE; s_axi_araddr = 32'h7000_0000;
        push_wb(1'b0, 32'h7000_0000, 32'h0, 4'hF);
        push_rsp(1'b0, 2'b00, 32'hFEED_FACE);
        issue(1'b0, 1'b0, 1'b1);
        collect(5);

        // Reset in the middle of a Wishbone cycle
        slv_mode = 2; s_axi_araddr = 32'h8000_0000;
        push_wb(1'b0, 32'h8000_0000, 32'h0, 4'hF);
        issue(1'b0, 1'b0, 1'b1);
        n = 0;
        while (!wb_stb && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_stb_seen", 32'(wb_stb), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_cyc_stb", 32'({wb_cyc, wb_stb}), 32'(0));
        check("mid_rst_valids", 32'({s_axi_bvalid, s_axi_rvalid}), 32'(0));
        check("mid_rst_arready", 32'(s_axi_arready), 32'(0));
        rst = 1'b0; slv_mode = 0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_resp", 32'({s_axi_bvalid, s_axi_rvalid, wb_cyc}), 32'(0));
        end
        slv_data = 32'h0C0F_FEE0; s_axi_araddr = 32'h9000_0000;
        push_wb(1'b0, 32'h9000_0000, 32'h0, 4'hF);
        push_rsp(1'b0, 2'b00, 32'h0C0F_FEE0);
        issue(1'b0, 1'b0, 1'b1);
        collect(0);

        repeat (3) @(negedge clk);
        check("wb_queue_empty", 32'(wb_exp.size()), 32'(0));
        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
